// File: rtl/tmu_conf_sequencer.sv
// Shadow/active configuration sequencer for one TMU: buffers config writes, drains the
// fragment pipeline on commit, then swaps all registers atomically. Optional: TMU_CONF_SKIP_UNCHANGED_EN.
module tmu_conf_sequencer #(
   parameter int PIPELINE_DEPTH = 11,
   parameter int PIXEL_WIDTH    = 32
) (
   input  logic                   aclk,
   input  logic                   reset,
   input  logic                   s_cfg_valid,
   output logic                   s_cfg_ready,
   input  logic [2:0]             s_cfg_sel,
   input  logic [31:0]            s_cfg_data,
   input  logic                   frag_valid_in,
   output logic                   frag_stall,
   output logic [31:0]            confFunc,
   output logic [PIXEL_WIDTH-1:0] confTextureEnvColor,
   output logic [31:0]            confTextureConfig,
   output logic                   confEnable,
   output logic                   commit_done,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

   localparam logic [2:0] SEL_FUNC   = 3'd0;
   localparam logic [2:0] SEL_ENV    = 3'd1;
   localparam logic [2:0] SEL_TEX    = 3'd2;
   localparam logic [2:0] SEL_ENABLE = 3'd3;
   localparam logic [2:0] SEL_COMMIT = 3'd4;

   state_t                  r_state;
   logic [PIPELINE_DEPTH-1:0] r_pipe;
   logic                    r_stall;
   logic                    r_done;

   logic [31:0]             r_sh_func;
   logic [PIXEL_WIDTH-1:0]  r_sh_env;
   logic [31:0]             r_sh_tex;
   logic                    r_sh_en;

   logic [31:0]             r_act_func;
   logic [PIXEL_WIDTH-1:0]  r_act_env;
   logic [31:0]             r_act_tex;
   logic                    r_act_en;

   logic w_accept;
   logic w_frag_take;
   logic w_pipe_empty;
   logic w_unchanged;

   assign s_cfg_ready  = (r_state == IDLE);
   assign w_accept     = s_cfg_valid && s_cfg_ready;
   assign w_frag_take  = frag_valid_in && !r_stall;
   assign w_pipe_empty = (r_pipe == '0);
   assign w_unchanged  = (r_sh_func == r_act_func) && (r_sh_env == r_act_env) &&
                         (r_sh_tex == r_act_tex) && (r_sh_en == r_act_en);

   assign frag_stall          = r_stall;
   assign commit_done         = r_done;
   assign busy                = (r_state != IDLE);
   assign confFunc            = r_act_func;
   assign confTextureEnvColor = r_act_env;
   assign confTextureConfig   = r_act_tex;
   assign confEnable          = r_act_en;

   // Each set bit is a fragment still inside the TMU; the oldest falls off the top.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         r_pipe <= '0;
      end else begin
         r_pipe <= (r_pipe << 1) | PIPELINE_DEPTH'(w_frag_take);
      end
   end

   // NOTE: every register in this block uses <= so all of them sample pre-edge values,
   // which is what makes the shadow-to-active copy atomic.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_stall    <= 1'b0;
         r_done     <= 1'b0;
         r_sh_func  <= '0;
         r_sh_env   <= '0;
         r_sh_tex   <= '0;
         r_sh_en    <= 1'b0;
         r_act_func <= '0;
         r_act_env  <= '0;
         r_act_tex  <= '0;
         r_act_en   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  case (s_cfg_sel)
                     SEL_FUNC:   r_sh_func <= s_cfg_data;
                     SEL_ENV:    r_sh_env  <= PIXEL_WIDTH'(s_cfg_data);
                     SEL_TEX:    r_sh_tex  <= s_cfg_data;
                     SEL_ENABLE: r_sh_en   <= s_cfg_data[0];
                     SEL_COMMIT: begin
`ifdef TMU_CONF_SKIP_UNCHANGED_EN
                        if (w_unchanged) begin
                           r_done <= 1'b1;
                        end else begin
                           r_state <= DRAIN;
                           r_stall <= 1'b1;
                        end
`else
                        r_state <= DRAIN;
                        r_stall <= 1'b1;
`endif
                     end
                     default: ;
                  endcase
               end
            end
            DRAIN: begin
               if (w_pipe_empty) r_state <= COMMIT;
            end
            COMMIT: begin
               r_act_func <= r_sh_func;
               r_act_env  <= r_sh_env;
               r_act_tex  <= r_sh_tex;
               r_act_en   <= r_sh_en;
               r_done     <= 1'b1;
               r_stall    <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifndef TMU_CONF_SKIP_UNCHANGED_EN
   logic w_unused;
   assign w_unused = w_unchanged;
`endif

endmodule

// File: doc/tmu_conf_sequencer.md
Name: tmu_conf_sequencer

Overview:
- Owns the live configuration of one TextureMappingUnit: confFunc, confTextureEnvColor, confTextureConfig and confEnable.
- Buffers configuration words from the command decoder in shadow registers.
- On a commit request, stalls fragment issue into the TMU and waits until the fixed-depth TMU pipeline drains.
- Then copies the shadow registers to the active outputs atomically, so no in-flight fragment ever sees a mixed configuration.

Parameters:
- PIPELINE_DEPTH, 11, TMU latency in cycles; sets the length of the in-flight tracking shift register.
- PIXEL_WIDTH, 32, width of confTextureEnvColor.

Ports:
- aclk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- s_cfg_valid  in  1  config/commit request valid
- s_cfg_ready  out  1  request accepted when valid && ready
- s_cfg_sel  in  3  0=func, 1=envColor, 2=textureConfig, 3=enable (bit0 of data), 4=commit, 5..7 reserved (accepted, ignored)
- s_cfg_data  in  32  payload; ignored for commit
- frag_valid_in  in  1  upstream presents a fragment to the TMU this cycle
- frag_stall  out  1  upstream must not issue; fragments presented while high are not counted
- confFunc  out  32  active TexEnv function
- confTextureEnvColor  out  PIXEL_WIDTH  active env colour
- confTextureConfig  out  32  active texture config
- confEnable  out  1  active TMU enable
- commit_done  out  1  one-cycle pulse, active outputs just updated
- busy  out  1  high while state != IDLE

Behaviour:
- Reset: the following are 0: all shadow and active registers, frag_stall, commit_done, busy, and the tracking shift register. State is IDLE; s_cfg_ready=1. Reset is honoured in any state; a pending commit is discarded and the shadow contents are lost.
- Fragment tracking: pipe[PIPELINE_DEPTH-1:0] shifts every cycle. pipe[0] is loaded with (frag_valid_in && !frag_stall). The TMU is empty when pipe==0.
- s_cfg_ready = (state==IDLE), combinational from the registered state.
- States: IDLE, DRAIN, COMMIT.
- IDLE: an accepted sel 0..3 write updates the addressed shadow register at the next edge. An accepted sel=4 sets state<=DRAIN and frag_stall<=1 (both registered). A fragment presented in the same cycle as the commit is still accepted and counted.
- DRAIN: if pipe==0, state<=COMMIT; otherwise remain in DRAIN. s_cfg_ready=0.
- COMMIT: all four active registers <= shadow in a single edge. commit_done<=1 for exactly one cycle, frag_stall<=0, state<=IDLE.
- Timing for commit accepted at cycle T with pipe empty and no fragment at T:
  - T+1: DRAIN.
  - T+2: COMMIT.
  - T+3: new active values visible; commit_done=1; frag_stall=0.
- Timing with a fragment accepted at T: pipe is nonzero for T+1..T+PIPELINE_DEPTH; COMMIT at T+PIPELINE_DEPTH+2; outputs update at T+PIPELINE_DEPTH+3 (T+14 for default).
- Shadow writes without a commit never change the active outputs.
- Back-to-back commits: the second is accepted at the earliest in the cycle commit_done is high, because s_cfg_ready returns to 1 in that same cycle.

Optional Feature:
- Macro: TMU_CONF_SKIP_UNCHANGED_EN.
- Defined: an accepted commit while all four shadow registers equal the active registers does not enter DRAIN. State stays IDLE, frag_stall stays 0, and commit_done pulses at T+1.
- Not defined: every commit takes the full DRAIN/COMMIT path, even when nothing changed.

Test Plan:
- Reset, then write sel0=0x0000_1234 and sel2=0x0000_0055 with no commit -> confFunc=0 and confTextureConfig=0 persist for 50 cycles; frag_stall=0.
- Write sel1=0xAABBCCDD and sel3=1, then commit at T with pipe empty -> frag_stall=1 at T+1..T+2; commit_done=1 only at T+3; confTextureEnvColor=0xAABBCCDD and confEnable=1 at T+3.
- frag_valid_in=1 continuously, commit at T -> exactly one extra fragment counted at T; fragments presented during stall are ignored; outputs update at T+14; frag_stall deasserts at T+14.
- Attempt a sel0 write while busy -> s_cfg_ready=0, write not taken; retried after commit_done -> lands in shadow only.
- Assert reset in DRAIN at T+5 -> all outputs 0 immediately (asynchronous), state IDLE, no commit_done afterwards.
- With TMU_CONF_SKIP_UNCHANGED_EN, commit twice with identical shadow -> first commit takes 3 cycles; second pulses commit_done at T+1 with frag_stall never high.
